bheap_host: RTL and testbench

BHEAP_HOST -- requirements
Module: bheap_host

---
 rtl/bheap_host.sv | 162 ++++++++++++++++
 tb/tb_bheap_host.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bheap_host.sv
// Host sequencer for a scan-chain binary-heap controller. It shifts keys in, starts
// a counted run, polls for completion, then shifts results out through a one-entry buffer.
`ifndef GlobalAddrWidth
`define GlobalAddrWidth 16
`endif
`ifndef GlobalDataWidth
`define GlobalDataWidth 16
`endif

module bheap_host #(
  parameter int                  WIDTH    = 8,
  parameter int                  IDWIDTH  = 8,
  parameter int                  CWIDTH   = 8,
  parameter int                  DEPTH    = 15,
  parameter logic [IDWIDTH-1:0]  CTRL_ID  = '0,
  parameter logic [IDWIDTH-1:0]  SCAN_ID  = IDWIDTH'(1),
  parameter int                  POLL_MAX = 255
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Start,
  input  logic [CWIDTH-1:0]            Iter,
  input  logic                         LdValid,
  output logic                         LdReady,
  input  logic [WIDTH-1:0]             LdData,
  output logic                         ResValid,
  input  logic                         ResReady,
  output logic [WIDTH-1:0]             ResData,
  output logic                         Busy,
  output logic                         Done,
  output logic                         Timeout,
  output logic                         RD,
  output logic                         WR,
  output logic [`GlobalAddrWidth-1:0]  Addr,
  output logic [`GlobalDataWidth-1:0]  BusOut,
  input  logic [`GlobalDataWidth-1:0]  BusIn
);

  localparam int AW = `GlobalAddrWidth;
  localparam int DW = `GlobalDataWidth;
  localparam int EW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(POLL_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_GO, S_POLL, S_UNLOAD, S_FIN
  } state_t;

  state_t            state, state_nx;
  logic [CWIDTH-1:0] iter_q;
  logic [EW-1:0]     elem_cnt;
  logic [PW-1:0]     poll_cnt;
  logic              elem_last;
  logic              poll_last;
  logic              poll_zero;
  logic              unload_rd;
  logic              bus_unused;

  assign elem_last  = (elem_cnt == EW'(DEPTH - 1));
  assign poll_last  = (poll_cnt == PW'(POLL_MAX));
  assign poll_zero  = (BusIn[CWIDTH-1:0] == '0);
  // A scan read is only issued when the result buffer has room this cycle.
  assign unload_rd  = (state == S_UNLOAD) && (elem_cnt < EW'(DEPTH)) && (!ResValid || ResReady);
  assign Busy       = (state != S_IDLE);
  assign bus_unused = ^BusIn;

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    RD       = 1'b0;
    WR       = 1'b0;
    Addr     = '0;
    BusOut   = '0;
    LdReady  = 1'b0;
    Done     = 1'b0;
    unique case (state)
      S_IDLE: if (Start) state_nx = S_LOAD;
      S_LOAD: begin
        LdReady = 1'b1;
        if (LdValid) begin
          WR     = 1'b1;
          Addr   = AW'(SCAN_ID);
          BusOut = DW'(LdData);
          if (elem_last) state_nx = S_GO;
        end
      end
      S_GO: begin
        WR       = 1'b1;
        Addr     = AW'(CTRL_ID);
        BusOut   = DW'(iter_q);
        state_nx = (iter_q != '0) ? S_POLL : S_UNLOAD;
      end
      S_POLL: begin
        RD   = 1'b1;
        Addr = AW'(CTRL_ID);
        // The first read still sees the pre-Go count, so it never ends the poll.
        if (poll_cnt != '0 && (poll_zero || poll_last)) state_nx = S_UNLOAD;
      end
      S_UNLOAD: begin
        if (unload_rd) begin
          RD   = 1'b1;
          Addr = AW'(SCAN_ID);
        end
        if (elem_cnt == EW'(DEPTH) && ResValid && ResReady) state_nx = S_FIN;
      end
      S_FIN: begin
        Done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    // Suppress strobes in the reset cycle so an aborted run leaves no half bus cycle.
    if (Reset) begin
      RD      = 1'b0;
      WR      = 1'b0;
      Addr    = '0;
      BusOut  = '0;
      LdReady = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (state == S_IDLE && Start) iter_q <= Iter;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Timeout  <= 1'b0;
      ResValid <= 1'b0;
      ResData  <= '0;
      elem_cnt <= '0;
      poll_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (Start) begin
          Timeout  <= 1'b0;
          elem_cnt <= '0;
        end
        S_LOAD: if (LdValid) elem_cnt <= elem_last ? '0 : elem_cnt + EW'(1);
        S_GO:   poll_cnt <= '0;
        S_POLL: begin
          if (!poll_last) poll_cnt <= poll_cnt + PW'(1);
          if (poll_cnt != '0 && !poll_zero && poll_last) Timeout <= 1'b1;
        end
        S_UNLOAD: begin
          if (unload_rd) begin
            ResValid <= 1'b1;
            ResData  <= BusIn[WIDTH-1:0];
            elem_cnt <= elem_cnt + EW'(1);
          end else if (ResValid && ResReady) begin
            ResValid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bheap_host.sv
// Directed bench for bheap_host: a bus-slave controller model plus a single
// sampling process that checks bus and handshake behaviour against run-level expectations.
`ifndef GlobalAddrWidth
`define GlobalAddrWidth 16
`endif
`ifndef GlobalDataWidth
`define GlobalDataWidth 16
`endif

module tb_bheap_host;
  localparam int DEPTH    = 3;
  localparam int POLL_MAX = 10;
  localparam int SCAN     = 1;
  localparam int CTRL     = 0;

  logic        Clk, Reset, Start, LdValid, LdReady, ResValid, ResReady;
  logic        Busy, Done, Timeout, RD, WR;
  logic [7:0]  Iter, LdData, ResData;
  logic [`GlobalAddrWidth-1:0] Addr;
  logic [`GlobalDataWidth-1:0] BusOut, BusIn;

  bheap_host #(
    .WIDTH(8), .IDWIDTH(8), .CWIDTH(8), .DEPTH(DEPTH),
    .CTRL_ID(8'(CTRL)), .SCAN_ID(8'(SCAN)), .POLL_MAX(POLL_MAX)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Iter(Iter),
    .LdValid(LdValid), .LdReady(LdReady), .LdData(LdData),
    .ResValid(ResValid), .ResReady(ResReady), .ResData(ResData),
    .Busy(Busy), .Done(Done), .Timeout(Timeout),
    .RD(RD), .WR(WR), .Addr(Addr), .BusOut(BusOut), .BusIn(BusIn)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Controller model: DEPTH-deep scan chain and a count that loads one cycle after Go.
  logic [7:0] chain [DEPTH];
  logic [7:0] cnt_reg, pend;
  logic       pend_v;
  bit         stuck;

  always_comb begin
    if (RD && Addr == SCAN) BusIn = 16'(chain[0]);
    else if (stuck)         BusIn = 16'd4;
    else                    BusIn = 16'(cnt_reg);
  end

  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) chain[i] <= '0;
      cnt_reg <= '0;
      pend    <= '0;
      pend_v  <= 1'b0;
    end else begin
      if ((WR || RD) && Addr == SCAN) begin
        for (int i = 0; i < DEPTH - 1; i++) chain[i] <= chain[i+1];
        chain[DEPTH-1] <= WR ? BusOut[7:0] : 8'd0;
      end
      if (WR && Addr == CTRL) begin
        pend   <= BusOut[7:0];
        pend_v <= 1'b1;
      end else if (pend_v) begin
        cnt_reg <= pend;
        pend_v  <= 1'b0;
      end else if (cnt_reg != 0) begin
        cnt_reg <= cnt_reg - 8'd1;
      end
    end
  end

  int total, bad, cyc, polls, scanrds, dones, stalls, go_cyc, first_rd, stall_left, run_polls;
  bit ld_acc, hold_prev;
  logic [7:0] hold_data;
  logic [7:0] wq[$], cq[$], rq[$];

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic monitor();
    chk(!(RD && WR), "rd_wr_excl", {RD, WR}, 0);
    if (!RD && !WR) chk(Addr == 0 && BusOut == 0, "quiet_bus", {Addr, BusOut}, 0);
    if (WR) chk(BusOut[15:8] == 0, "busout_zext", BusOut, BusOut[7:0]);
    if (Done) chk(Busy, "done_busy", Busy, 1);
    if (hold_prev) begin
      chk(ResValid, "res_valid_hold", ResValid, 1);
      chk(ResData == hold_data, "res_data_hold", ResData, hold_data);
    end
    if (ResValid && !ResReady) begin
      chk(!RD, "rd_while_full", RD, 0);
      stalls++;
    end
    hold_prev = ResValid && !ResReady;
    hold_data = ResData;
    if (WR && Addr == SCAN) wq.push_back(BusOut[7:0]);
    if (WR && Addr == CTRL) begin
      cq.push_back(BusOut[7:0]);
      go_cyc   = cyc;
      first_rd = -1;
    end
    if (RD && Addr == CTRL) polls++;
    if (RD && Addr == SCAN) begin
      scanrds++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (ResValid && ResReady) rq.push_back(ResData);
    if (Done) dones++;
    ld_acc = LdValid && LdReady;
    cyc++;
  endtask

  // One clock: sample at negedge, then update ResReady just after the active edge.
  task automatic tick();
    @(negedge Clk);
    monitor();
    @(posedge Clk);
    #1;
    if (ResValid && stall_left > 0) begin
      ResReady   = 1'b0;
      stall_left = stall_left - 1;
    end else begin
      ResReady = 1'b1;
    end
  endtask

  task automatic load_one(input logic [7:0] v);
    int n;
    LdValid = 1'b1;
    LdData  = v;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ld_acc && n < 20);
    chk(ld_acc, "load_accept", ld_acc, 1);
    LdValid = 1'b0;
  endtask

  task automatic run_seq(input logic [7:0] it, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input bit stk, input int stall);
    logic [7:0] ld [3];
    int wb, cb, rb, pb, sb, db, stb, exp_polls, n;
    bit exp_to;
    ld[0] = a; ld[1] = b; ld[2] = c;
    wb = wq.size(); cb = cq.size(); rb = rq.size();
    pb = polls; sb = scanrds; db = dones; stb = stalls;
    stuck = stk;
    stall_left = stall;
    // Expected poll reads: one discarded, then counts it..0, bounded by POLL_MAX.
    if (it == 0)                   exp_polls = 0;
    else if (stk)                  exp_polls = POLL_MAX + 1;
    else if (it + 2 > POLL_MAX + 1) exp_polls = POLL_MAX + 1;
    else                           exp_polls = it + 2;
    exp_to = (it != 0) && (stk || (it + 2 > POLL_MAX + 1));

    Start = 1'b1; Iter = it;
    tick();
    Start = 1'b0; Iter = 8'd0;
    chk(Busy, "busy_after_start", Busy, 1);
    load_one(ld[0]);
    Start = 1'b1; Iter = 8'd7;
    tick();
    Start = 1'b0; Iter = 8'd0;
    load_one(ld[1]);
    load_one(ld[2]);
    n = 0;
    while (dones == db && n < 300) begin
      tick();
      n++;
    end
    chk(dones > db, "done_seen", dones - db, 1);
    repeat (3) tick();

    chk(wq.size() - wb == DEPTH, "scan_write_count", wq.size() - wb, DEPTH);
    for (int k = 0; k < DEPTH; k++)
      if (wb + k < wq.size()) chk(wq[wb+k] == ld[k], "scan_write_data", wq[wb+k], ld[k]);
    chk(cq.size() - cb == 1, "go_write_count", cq.size() - cb, 1);
    if (cb < cq.size()) chk(cq[cb] == it, "go_write_data", cq[cb], it);
    run_polls = polls - pb;
    chk(run_polls == exp_polls, "poll_reads", run_polls, exp_polls);
    chk(scanrds - sb == DEPTH, "scan_reads", scanrds - sb, DEPTH);
    chk(rq.size() - rb == DEPTH, "result_count", rq.size() - rb, DEPTH);
    for (int k = 0; k < DEPTH; k++)
      if (rb + k < rq.size()) chk(rq[rb+k] == ld[k], "result_data", rq[rb+k], ld[k]);
    chk(dones - db == 1, "done_once", dones - db, 1);
    chk(Timeout == exp_to, "timeout_flag", Timeout, exp_to);
    chk(stalls - stb == stall, "stall_cycles", stalls - stb, stall);
    chk(!Busy, "idle_after_run", Busy, 0);
    if (it == 0) chk(first_rd - go_cyc == 1, "unload_next_cycle", first_rd - go_cyc, 1);
    stuck = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({RD, WR, LdReady, ResValid, Busy, Done, Timeout} == 0, {nm, "_ctrl"},
        {RD, WR, LdReady, ResValid, Busy, Done, Timeout}, 0);
    chk(Addr == 0 && BusOut == 0 && ResData == 0, {nm, "_data"}, {Addr, BusOut, ResData}, 0);
  endtask

  initial begin
    int n, pb;
    total = 0; bad = 0; cyc = 0; polls = 0; scanrds = 0; dones = 0; stalls = 0;
    go_cyc = 0; first_rd = -1; stall_left = 0; run_polls = 0;
    ld_acc = 1'b0; hold_prev = 1'b0; hold_data = '0; stuck = 1'b0;
    Reset = 1'b1; Start = 1'b0; Iter = '0; LdValid = 1'b0; LdData = '0; ResReady = 1'b1;
    @(posedge Clk); #1;
    tick();
    tick();
    chk_all_zero("reset_state");
    Reset = 1'b0;
    tick();

    // Basic run: chain order out, four poll reads (stale, 2, 1, 0).
    run_seq(8'd2, 8'd5, 8'd9, 8'd2, 1'b0, 0);
    chk(run_polls == 4, "lit_polls_iter2", run_polls, 4);
    chk(rq.size() >= 3 && rq[rq.size()-3] == 8'd5 && rq[rq.size()-1] == 8'd2,
        "lit_results_592", rq.size(), 3);

    // Zero iterations: Go goes straight to unload.
    run_seq(8'd0, 8'd7, 8'd1, 8'd3, 1'b0, 0);
    chk(run_polls == 0, "lit_polls_iter0", run_polls, 0);

    // Stuck count: poll times out after 1 + POLL_MAX reads.
    run_seq(8'd4, 8'd10, 8'd20, 8'd30, 1'b1, 0);
    chk(run_polls == 11, "lit_polls_stuck", run_polls, 11);
    chk(Timeout == 1'b1, "lit_timeout_sticky", Timeout, 1);

    // Result back-pressure for five cycles.
    run_seq(8'd1, 8'hAA, 8'h55, 8'hFF, 1'b0, 5);
    chk(Timeout == 1'b0, "timeout_cleared", Timeout, 0);

    // Reset during POLL, with Start held in the reset cycle.
    pb = polls;
    Start = 1'b1; Iter = 8'd5;
    tick();
    Start = 1'b0; Iter = 8'd0;
    load_one(8'd11);
    load_one(8'd12);
    load_one(8'd13);
    n = 0;
    while (polls - pb < 2 && n < 50) begin
      tick();
      n++;
    end
    chk(polls - pb >= 2, "reached_poll", polls - pb, 2);
    Reset = 1'b1; Start = 1'b1; Iter = 8'd9;
    tick();
    Reset = 1'b0; Start = 1'b0; Iter = 8'd0;
    chk_all_zero("mid_run_reset");
    tick();
    tick();
    chk(!Busy, "start_in_reset_ignored", Busy, 0);
    run_seq(8'd3, 8'd1, 8'd2, 8'd3, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
